// File: rtl/nota_serial_tx.sv
// UART 8N1 transmitter reporting game events (note a..d, win 'W', ready 'R') to the PC.
// Edge-detected events are arbitrated into a 4-entry FIFO and shifted out LSB first.
module nota_serial_tx #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] notaSalida,
    input  logic       resultado,
    input  logic       juegoListo,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned WAIT_W     = 4;
    localparam int unsigned NSRC       = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic [2:0]        nota_prev_q;
    logic              res_prev_q, listo_prev_q;
    logic [NSRC-1:0]   pend_q, pend_d;
    logic [WAIT_W-1:0] wait_q [NSRC];
    logic [WAIT_W-1:0] wait_d [NSRC];
    logic [7:0]        note_byte_q, note_byte_d;
    logic              overflow_q, overflow_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q, count_d;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    logic              note_ev_c;
    logic [NSRC-1:0]   ev_c, grant_c, drop_c;
    logic              fifo_full_c, push_c, pop_c;
    logic [7:0]        push_data_c;

    // Event detection and pending/arbitration; bit 0 = note (highest priority), 1 = win, 2 = ready.
    always_comb begin
        note_ev_c   = (notaSalida >= 3'd1) && (notaSalida <= 3'd4) && (notaSalida != nota_prev_q);
        ev_c        = {juegoListo & ~listo_prev_q, resultado & ~res_prev_q, note_ev_c};
        fifo_full_c = (count_q == 3'(FIFO_DEPTH));
        grant_c     = fifo_full_c ? '0 : (pend_q & NSRC'(~pend_q + NSRC'(1)));
        push_c      = |grant_c;
        push_data_c = grant_c[0] ? note_byte_q : (grant_c[1] ? 8'd87 : 8'd82);
        note_byte_d = note_ev_c ? 8'(8'd96 + 8'(notaSalida)) : note_byte_q;
        pend_d      = pend_q;
        drop_c      = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            wait_d[i] = '0;
            drop_c[i] = pend_q[i] & fifo_full_c & (wait_q[i] == {WAIT_W{1'b1}});
            if (pend_q[i] && fifo_full_c && !drop_c[i]) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
            pend_d[i] = (pend_q[i] & ~grant_c[i] & ~drop_c[i]) | ev_c[i];
        end
        overflow_d = overflow_q | (|drop_c);
    end

    // TX framing FSM: next state, shift control and next line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (count_q != 3'd0) begin
                    pop_c   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        count_d = count_q + 3'(push_c) - 3'(pop_c);
        busy_d  = (state_d != S_IDLE) || (count_d != 3'd0) || (|pend_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            nota_prev_q  <= '0;
            res_prev_q   <= 1'b0;
            listo_prev_q <= 1'b0;
            pend_q       <= '0;
            for (int i = 0; i < int'(NSRC); i++) wait_q[i] <= '0;
            note_byte_q  <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            nota_prev_q  <= notaSalida;
            res_prev_q   <= resultado;
            listo_prev_q <= juegoListo;
            pend_q       <= pend_d;
            for (int i = 0; i < int'(NSRC); i++) wait_q[i] <= wait_d[i];
            note_byte_q  <= note_byte_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_q + PTR_W'(push_c);
            rd_ptr_q     <= rd_ptr_q + PTR_W'(pop_c);
            count_q      <= count_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= push_data_c;
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
